// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI engine port arbiter.
package spi_arb_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  localparam logic ID_FETCH = 1'b0;
  localparam logic ID_DATA  = 1'b1;

  localparam logic [DATA_W-1:0] ERR_BYTE = 8'hFF;

endpackage

// File: rtl/spi_port_arbiter.sv
// Round-robin arbiter between instruction fetch and data reads for the shared
// SPI byte-read engine, with inter-transaction gap and completion timeout.
module spi_port_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              rerr,
  output logic              eng_start,
  output logic [ADDR_W-1:0] eng_addr,
  input  logic              eng_busy,
  input  logic              eng_done,
  input  logic [DATA_W-1:0] eng_data,
  output logic              busy
);

  localparam int unsigned TO_W  = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned GAP_W = ($clog2(GAP_CYCLES + 1) < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  arb_state_e        state;
  logic              cur_id;
  logic              last_id;
  logic [TO_W-1:0]   to_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  logic              req_any_c;
  logic              win_id_c;
  logic [ADDR_W-1:0] win_addr_c;

  // Winner selection: a lone requester wins, a tie goes to whoever was not granted last.
  always_comb begin
    req_any_c = f_req | d_req;
    win_id_c  = ID_DATA;
    if (f_req && d_req) begin
      win_id_c = (last_id == ID_DATA) ? ID_FETCH : ID_DATA;
    end else if (f_req) begin
      win_id_c = ID_FETCH;
    end
    win_addr_c = (win_id_c == ID_FETCH) ? f_addr : d_addr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cur_id    <= ID_FETCH;
      last_id   <= ID_DATA;
      to_cnt    <= '0;
      gap_cnt   <= '0;
      f_gnt     <= 1'b0;
      d_gnt     <= 1'b0;
      f_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      rdata     <= '0;
      rerr      <= 1'b0;
      eng_start <= 1'b0;
      eng_addr  <= '0;
      busy      <= 1'b0;
    end else begin
      f_gnt     <= 1'b0;
      d_gnt     <= 1'b0;
      f_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      eng_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_any_c && !eng_busy) begin
            state     <= ST_WAIT;
            busy      <= 1'b1;
            eng_start <= 1'b1;
            eng_addr  <= win_addr_c;
            cur_id    <= win_id_c;
            last_id   <= win_id_c;
            f_gnt     <= (win_id_c == ID_FETCH);
            d_gnt     <= (win_id_c == ID_DATA);
            to_cnt    <= '0;
          end
        end
        ST_WAIT: begin
          // A done arriving on the final counted cycle still beats the timeout.
          if (eng_done || (to_cnt == TO_LAST)) begin
            rdata    <= eng_done ? eng_data : ERR_BYTE;
            rerr     <= !eng_done;
            f_rvalid <= (cur_id == ID_FETCH);
            d_rvalid <= (cur_id == ID_DATA);
            to_cnt   <= '0;
            gap_cnt  <= '0;
            if (GAP_CYCLES == 0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= ST_GAP;
            end
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
